// File: rtl/neuron_ctrl_pkg.sv
// Shared definitions for the neuron evaluation controller: FSM encoding and
// latency constants (3 cycles per element plus 4 fixed cycles).
package neuron_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LOAD,
    S_MAC,
    S_ACT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int unsigned CYCLES_PER_ELEM = 3;
  localparam int unsigned FIXED_CYCLES    = 4;

  function automatic int unsigned op_latency(input int unsigned n);
    return CYCLES_PER_ELEM * n + FIXED_CYCLES;
  endfunction

endpackage

// File: rtl/neuron_ctrl_dim_counter.sv
// Element index counter with clear/increment and a terminal flag at idx==limit-1.
// Single-cycle update; no backpressure, the FSM decides when to step.
module dim_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-2:0] idx,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_nxt;

  // Compare against idx+1 so limit==0 cannot underflow; W bits hold limit==2^(W-1).
  always_comb begin
    cnt_nxt = cnt_q + W'(1);
    last    = (cnt_nxt == limit);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idx = cnt_q[W-2:0];

endmodule

// File: rtl/neuron_ctrl.sv
// Sequences one neuron evaluation: clear, len x (fetch, load, mac), activate, write.
// Latency 3*len+4 cycles; start is only sampled in IDLE, requests while busy are dropped.
module neuron_ctrl
  import neuron_ctrl_pkg::*;
#(
  parameter int Q = 4,
  parameter int d = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [d:0]   len,
  input  logic [Q-1:0] base_x,
  input  logic [Q-1:0] base_w,
  output logic         busy,
  output logic         done,
  output logic         clear_acc,
  output logic         acc_en,
  output logic         ready,
  output logic         res_write,
  output logic         memRead_x,
  output logic         memRead_w,
  output logic         x_write,
  output logic         w_write,
  output logic [Q-1:0] addr_x,
  output logic [Q-1:0] addr_w,
  output logic [d-1:0] index_d_x,
  output logic [d-1:0] index_d_w
);

  state_t       state_q, state_d;
  logic [d:0]   len_q, len_d;
  logic [Q-1:0] base_x_q, base_x_d;
  logic [Q-1:0] base_w_q, base_w_d;

  logic         accept;
  logic         idx_inc;
  logic         idx_last;
  logic [d-1:0] idx;

  assign accept  = (state_q == S_IDLE) && start;
  assign idx_inc = (state_q == S_MAC) && !idx_last;

  dim_counter #(
    .W(d + 1)
  ) u_dim_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (idx_inc),
    .limit(len_q),
    .idx  (idx),
    .last (idx_last)
  );

  // Operands are captured once so input changes mid-operation are invisible.
  always_comb begin
    len_d    = len_q;
    base_x_d = base_x_q;
    base_w_d = base_w_q;
    if (accept) begin
      len_d    = len;
      base_x_d = base_x;
      base_w_d = base_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      base_x_q <= '0;
      base_w_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      base_x_q <= base_x_d;
      base_w_q <= base_w_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = (len_q != '0) ? S_FETCH : S_ACT;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_MAC;
      S_MAC:   state_d = idx_last ? S_ACT : S_FETCH;
      S_ACT:   state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    clear_acc = 1'b0;
    acc_en    = 1'b0;
    ready     = 1'b0;
    res_write = 1'b0;
    memRead_x = 1'b0;
    memRead_w = 1'b0;
    x_write   = 1'b0;
    w_write   = 1'b0;
    case (state_q)
      S_CLEAR: clear_acc = 1'b1;
      S_FETCH: begin
        memRead_x = 1'b1;
        memRead_w = 1'b1;
      end
      S_LOAD: begin
        x_write = 1'b1;
        w_write = 1'b1;
      end
      S_MAC:   acc_en = 1'b1;
      S_ACT:   ready  = 1'b1;
      S_WRITE: begin
        ready     = 1'b1;
        res_write = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign addr_x    = base_x_q;
  assign addr_w    = base_w_q;
  assign index_d_x = idx;
  assign index_d_w = idx;

endmodule

// File: tb/tb_neuron_ctrl.sv
// Directed bench for neuron_ctrl: latency, enable counts, index sequence,
// back-to-back starts, mid-operation reset and operand isolation.
module tb_neuron_ctrl;
  import neuron_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len_i = '0;
  logic [3:0] base_x_i = '0;
  logic [3:0] base_w_i = '0;
  logic       busy, done, clear_acc, acc_en, ready, res_write;
  logic       memRead_x, memRead_w, x_write, w_write;
  logic [3:0] addr_x, addr_w;
  logic [2:0] index_d_x, index_d_w;

  int checks = 0;
  int errors = 0;

  int n_acc, n_rd, n_clr, n_rdy_rise, n_wr, n_xw, n_busy_low;
  int n_addr_bad, n_idx_bad, n_pair_bad, n_fetch, act_idx;
  logic first_clear, prev_ready;
  logic [2:0] fetch_idx [16];

  wire [23:0] all_outs = {busy, done, clear_acc, acc_en, ready, res_write,
                          memRead_x, memRead_w, x_write, w_write,
                          addr_x, addr_w, index_d_x, index_d_w};

  neuron_ctrl #(.Q(4), .d(3)) dut (
    .clk(clk), .rst(rst_n), .start(start), .len(len_i),
    .base_x(base_x_i), .base_w(base_w_i),
    .busy(busy), .done(done), .clear_acc(clear_acc), .acc_en(acc_en),
    .ready(ready), .res_write(res_write),
    .memRead_x(memRead_x), .memRead_w(memRead_w),
    .x_write(x_write), .w_write(w_write),
    .addr_x(addr_x), .addr_w(addr_w),
    .index_d_x(index_d_x), .index_d_w(index_d_w)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic launch(input logic [3:0] l, input logic [3:0] bx, input logic [3:0] bw);
    @(negedge clk);
    start    = 1'b1;
    len_i    = l;
    base_x_i = bx;
    base_w_i = bw;
  endtask

  // Observes cycles 1..max_c after the start-sampling edge; done_c=0 on timeout.
  task automatic collect(input int max_c, input bit drop_start, input bit chg,
                         input logic [3:0] exp_bx, input logic [3:0] exp_bw,
                         output int done_c);
    done_c = 0; n_acc = 0; n_rd = 0; n_clr = 0; n_rdy_rise = 0; n_wr = 0;
    n_xw = 0; n_busy_low = 0; n_addr_bad = 0; n_idx_bad = 0; n_pair_bad = 0;
    n_fetch = 0; act_idx = -1; first_clear = 1'b0; prev_ready = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (drop_start) start = 1'b0;
        if (chg) begin
          len_i = 4'd1; base_x_i = 4'hF; base_w_i = 4'h0;
        end
        first_clear = clear_acc;
      end
      if (acc_en) n_acc++;
      if (clear_acc) n_clr++;
      if (res_write) n_wr++;
      if (x_write) n_xw++;
      if (ready && !prev_ready) n_rdy_rise++;
      prev_ready = ready;
      if (memRead_x) begin
        n_rd++;
        if (n_fetch < 16) fetch_idx[n_fetch] = index_d_x;
        n_fetch++;
      end
      if (ready && !res_write && act_idx < 0) act_idx = int'(index_d_x);
      if (memRead_x !== memRead_w || x_write !== w_write) n_pair_bad++;
      if (index_d_x !== index_d_w) n_idx_bad++;
      if (addr_x !== exp_bx || addr_w !== exp_bw) n_addr_bad++;
      if (busy !== 1'b1) n_busy_low++;
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (all_outs !== 24'h0) begin errors++; $display("FAIL reset_outs got %h exp 0", all_outs); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (all_outs !== 24'h0) begin errors++; $display("FAIL post_reset_idle got %h exp 0", all_outs); end
  endtask

  task automatic test_len3();
    int dc;
    launch(4'd3, 4'd2, 4'd5);
    collect(60, 1'b1, 1'b0, 4'd2, 4'd5, dc);
    checks++; if (dc !== 13) begin errors++; $display("FAIL len3_latency got %0d exp 13", dc); end
    checks++; if (dc !== int'(op_latency(3))) begin errors++; $display("FAIL len3_pkg_latency got %0d exp %0d", dc, op_latency(3)); end
    checks++; if (n_fetch !== 3) begin errors++; $display("FAIL len3_fetches got %0d exp 3", n_fetch); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_idx[i] !== 3'(i)) begin errors++; $display("FAIL len3_idx%0d got %0d exp %0d", i, fetch_idx[i], i); end
    end
    checks++; if (n_acc !== 3 || n_xw !== 3) begin errors++; $display("FAIL len3_acc_xw got %0d/%0d exp 3/3", n_acc, n_xw); end
    checks++; if (n_clr !== 1 || n_wr !== 1 || n_rdy_rise !== 1) begin errors++; $display("FAIL len3_clr_wr_rdy got %0d/%0d/%0d exp 1/1/1", n_clr, n_wr, n_rdy_rise); end
    checks++; if (n_addr_bad !== 0) begin errors++; $display("FAIL len3_addr bad cycles %0d exp 0", n_addr_bad); end
    checks++; if (n_idx_bad !== 0 || n_pair_bad !== 0) begin errors++; $display("FAIL len3_pairs got %0d/%0d exp 0/0", n_idx_bad, n_pair_bad); end
    checks++; if (n_busy_low !== 0) begin errors++; $display("FAIL len3_busy low cycles %0d exp 0", n_busy_low); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL len3_idle_after busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_len0();
    int dc;
    launch(4'd0, 4'd1, 4'd1);
    collect(20, 1'b1, 1'b0, 4'd1, 4'd1, dc);
    checks++; if (dc !== 4) begin errors++; $display("FAIL len0_latency got %0d exp 4", dc); end
    checks++; if (n_rd !== 0 || n_acc !== 0 || n_xw !== 0) begin errors++; $display("FAIL len0_no_mac rd=%0d acc=%0d xw=%0d exp 0", n_rd, n_acc, n_xw); end
    checks++; if (n_clr !== 1 || n_rdy_rise !== 1 || n_wr !== 1) begin errors++; $display("FAIL len0_ctrl got %0d/%0d/%0d exp 1/1/1", n_clr, n_rdy_rise, n_wr); end
  endtask

  task automatic test_len8();
    int dc;
    launch(4'd8, 4'd7, 4'd3);
    collect(80, 1'b1, 1'b0, 4'd7, 4'd3, dc);
    checks++; if (dc !== 28) begin errors++; $display("FAIL len8_latency got %0d exp 28", dc); end
    checks++; if (n_acc !== 8) begin errors++; $display("FAIL len8_acc got %0d exp 8", n_acc); end
    checks++; if (n_fetch !== 8) begin errors++; $display("FAIL len8_fetches got %0d exp 8", n_fetch); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (fetch_idx[i] !== 3'(i)) begin errors++; $display("FAIL len8_idx%0d got %0d exp %0d", i, fetch_idx[i], i); end
    end
    checks++; if (act_idx !== 7) begin errors++; $display("FAIL len8_final_idx got %0d exp 7", act_idx); end
  endtask

  task automatic test_back_to_back();
    int dc;
    launch(4'd2, 4'd3, 4'd4);
    collect(40, 1'b0, 1'b0, 4'd3, 4'd4, dc);
    checks++; if (dc !== 10 || first_clear !== 1'b1) begin errors++; $display("FAIL b2b_first lat=%0d clr=%b exp 10/1", dc, first_clear); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || clear_acc !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy=%b clr=%b exp 0/0", busy, clear_acc); end
    collect(40, 1'b1, 1'b0, 4'd3, 4'd4, dc);
    checks++; if (first_clear !== 1'b1) begin errors++; $display("FAIL b2b_clear_after_2 got %b exp 1", first_clear); end
    checks++; if (dc !== 10 || n_acc !== 2) begin errors++; $display("FAIL b2b_second lat=%0d acc=%0d exp 10/2", dc, n_acc); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_abort();
    int n;
    int dc;
    int seen_done;
    n = 0;
    seen_done = 0;
    launch(4'd5, 4'd6, 4'd9);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (acc_en) n++;
      if (n == 3) break;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL abort_reach_mac3 got %0d exp 3", n); end
    rst_n = 1'b0;
    #1;
    checks++; if (all_outs !== 24'h0) begin errors++; $display("FAIL abort_outs got %h exp 0", all_outs); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done bad cycles %0d exp 0", seen_done); end
    launch(4'd5, 4'd6, 4'd9);
    collect(60, 1'b1, 1'b0, 4'd6, 4'd9, dc);
    checks++; if (dc !== 19 || n_acc !== 5) begin errors++; $display("FAIL abort_rerun lat=%0d acc=%0d exp 19/5", dc, n_acc); end
  endtask

  task automatic test_len_change();
    int dc;
    launch(4'd4, 4'hA, 4'hB);
    collect(60, 1'b1, 1'b1, 4'hA, 4'hB, dc);
    checks++; if (n_acc !== 4) begin errors++; $display("FAIL lenchg_acc got %0d exp 4", n_acc); end
    checks++; if (dc !== 16) begin errors++; $display("FAIL lenchg_latency got %0d exp 16", dc); end
    checks++; if (n_addr_bad !== 0) begin errors++; $display("FAIL lenchg_addr bad cycles %0d exp 0", n_addr_bad); end
  endtask

  initial begin
    test_reset();
    test_len3();
    test_len0();
    test_len8();
    test_back_to_back();
    test_reset_abort();
    test_len_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_ctrl.md
NEURON_CTRL -- requirements
Module: neuron_ctrl

Interface
REQ-001 The block SHALL have parameters: Q, default 4, address width of the x/w memories; d, default 3, dimension-index width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one neuron evaluation; sampled only in IDLE.
REQ-005 len  input  d+1  number of elements to accumulate, 0..2^d; latched on accepted start.
REQ-006 base_x, base_w  input  Q each  memory row addresses; latched on accepted start.
REQ-007 busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-008 done  output  1  one-cycle pulse when the result register has been written.
REQ-009 clear_acc, acc_en, ready, res_write  output  1 each  datapath accumulator and activation/result controls.
REQ-010 memRead_x, memRead_w, x_write, w_write  output  1 each  memory read and operand-register write enables.
REQ-011 addr_x, addr_w  output  Q each  latched base_x/base_w, held constant for the whole operation.
REQ-012 index_d_x, index_d_w  output  d each  current element index; both always equal.

Function
REQ-013 The FSM SHALL use states IDLE, CLEAR, FETCH, LOAD, MAC, ACT, WRITE, DONE.
REQ-014 IDLE: start=1 -> CLEAR; latch len, base_x, base_w; clear index to 0.
REQ-015 CLEAR (1 cycle): clear_acc=1; -> FETCH if latched len!=0, else -> ACT.
REQ-016 FETCH (1 cycle): memRead_x=memRead_w=1 at the current index; memory data is valid the following cycle; -> LOAD.
REQ-017 LOAD (1 cycle): x_write=w_write=1; -> MAC.
REQ-018 MAC (1 cycle): acc_en=1; if index==len-1 -> ACT, else increment index and -> FETCH.
REQ-019 ACT (1 cycle): ready=1; -> WRITE.
REQ-020 WRITE (1 cycle): ready=1, res_write=1; -> DONE.
REQ-021 DONE (1 cycle): done=1; -> IDLE; start is not sampled in DONE.
REQ-022 All control outputs SHALL be Moore outputs decoded from state only; each enable is high only in the states listed above.
REQ-023 Total latency from the start-sampling edge to the done-high cycle SHALL be 3*len+4 cycles (len=0 -> 4).
REQ-024 start while busy SHALL be ignored; there is no queueing.
REQ-025 The index counter SHALL be d+1 bits internally so that len=2^d terminates correctly; index_d_x/w output its low d bits.
REQ-026 Changes to len/base_x/base_w while busy SHALL NOT affect the operation in flight.

Reset
REQ-027 rst low SHALL immediately force IDLE, index 0, latched len/base 0, and every output 0, including mid-operation; no done is produced for an aborted operation.
REQ-028 After rst deasserts, the first start is accepted on the next rising edge at which it is sampled high.

Structure
REQ-029 A shared package SHALL hold the state enumeration and the per-element cycle constant (3) used by the bench latency checks.
REQ-030 The index counter SHALL be one sub-module, dim_counter (clear, increment, terminal compare against len).

Verification
REQ-031 len=3, base_x=2, base_w=5, start pulse -> index 0,1,2 in successive FETCH cycles; addr_x=2, addr_w=5 throughout; done in the 13th cycle after the start-sampling edge.
REQ-032 len=0 -> clear_acc, ready, res_write each asserted once; no memRead/acc_en; done 4 cycles after start.
REQ-033 len=8 (d=3) -> exactly 8 acc_en pulses, final index 7, no wrap to 0 before ACT; done after 28 cycles.
REQ-034 start held high continuously with len=2 -> one operation per IDLE visit; each done followed by a new CLEAR exactly 2 cycles later.
REQ-035 rst low during the third MAC of len=5 -> all outputs 0 immediately; no done; next start runs a full len=5 with the correct latency.
REQ-036 len changed from 4 to 1 one cycle after start -> 4 acc_en pulses still issued.
